id_hazard_fwd_unit: RTL and testbench
=====================================

Name: id_hazard_fwd_unit

Overview:
Next-generation ID-stage forwarding and hazard unit for the 5-stage MIPS pipeline.
- Generalised over operand count and register-address width.
- Forwards from both EX/MEM and MEM/WB into ID-stage operands for branch compare and jr.
- Owns a bubble-countdown FSM that issues multi-cycle stalls for load-use and branch-on-unresolved-result hazards.
- Keeps a saturating stall-cycle performance counter.
- Sits between the hazard inputs from ID/EX/MEM/WB and the PC, IF/ID and ID/EX control.

Parameters:
- NUM_SRC, 2, number of ID-stage source operands checked (rs, rt, ...).
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  reset, synchronous, active-high.
- src_id  in  NUM_SRC*REG_AW  ID source register addresses; operand k is bits [k*REG_AW +: REG_AW].
- src_used  in  NUM_SRC  bit k=1: operand k is actually read by the ID instruction.
- is_branch_id  in  1  ID instruction consumes operands in ID (beq/bne/jr/jalr).
- rd_ex  in  REG_AW  destination register in EX.
- reg_write_ex  in  1  EX instruction writes the register file.
- mem_read_ex  in  1  EX instruction is a load.
- rd_mem  in  REG_AW  destination register in MEM.
- reg_write_mem  in  1  MEM instruction writes the register file.
- mem_read_mem  in  1  MEM instruction is a load.
- rd_wb  in  REG_AW  destination register in WB.
- reg_write_wb  in  1  WB instruction writes the register file.
- hold  in  1  external pipeline freeze (memory not ready); pauses the FSM.
- flush  in  1  taken branch or exception; kills the ID instruction.
- fwd_sel  out  2*NUM_SRC  per operand: 00 regfile, 01 EX/MEM result, 10 MEM/WB result; 11 never driven.
- stall  out  1  freeze PC and IF/ID.
- bubble_ex  out  1  insert a NOP into ID/EX.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset, synchronous and active-high:
  - state=IDLE, remaining=0, stall_cnt=0.
  - While reset is high, stall=0, bubble_ex=0 and fwd_sel=0.
- Match rule: operand k matches stage S when src_used[k], reg_write_S, rd_S==src_k and rd_S!=0. Register 0 never matches.
- fwd_sel is combinational and evaluated every cycle, including during stalls:
  - 01 if operand k matches MEM and mem_read_mem=0.
  - Otherwise 10 if operand k matches WB.
  - Otherwise 00.
  - MEM takes priority over WB.
- Required bubbles (need), taken as the maximum over all operands:
  - Operand matches EX and mem_read_ex, is_branch_id=1: need=2.
  - Operand matches EX and mem_read_ex, is_branch_id=0: need=1.
  - Operand matches EX, not a load, is_branch_id=1: need=1.
  - Operand matches MEM, mem_read_mem, is_branch_id=1: need=1.
  - Any other case: need=0.
- FSM states:
  - IDLE:
    - need>0 and flush=0: stall=1 and bubble_ex=1 this cycle (combinational). If hold=0, go to STALL with remaining=need-1, or stay IDLE if need-1==0.
    - need=0: no stall.
  - STALL:
    - stall=1, bubble_ex=1.
    - hold=0: remaining decrements; go to IDLE when it reaches 0.
    - hold=1: remaining is frozen, stall stays 1.
- hold in IDLE: no state change; stall still follows need.
- flush has priority over everything: stall=0, bubble_ex=0, next state IDLE, remaining=0, in the same cycle.
- flush and hold together: flush wins.
- stall_cnt increments on every cycle with stall=1 and hold=0, and saturates at all-ones (no wrap).
- Reset asserted mid-stall returns to IDLE on the next edge, with stall_cnt=0.
- All outputs other than fwd_sel are glitch-free functions of the registered state plus the current-cycle need and flush.

Decomposition:
- Shared package (mips_pkg):
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - State encoding IDLE/STALL.
  - REG_ZERO constant.
- One natural sub-module: id_src_match, one instance per operand via generate. It produces fwd_sel[k] and need[k]. The top level max-reduces need and holds the FSM and counter.

Test Plan:
- No-hazard / regfile path: reg_write_mem=1 rd_mem=0, src_id rs=0 -> fwd_sel=00, stall=0.
- MEM vs WB priority: rs=8 matches rd_mem=8 (ALU) and rd_wb=8 -> fwd_sel[rs]=01. Same rt=9 matches only rd_wb=9 -> fwd_sel[rt]=10.
- Load-then-beq: rd_ex=5 mem_read_ex=1, beq rs=5.
  - stall/bubble_ex high for exactly 2 cycles as the load moves EX->MEM->WB.
  - fwd_sel[rs]=10 on release.
  - stall_cnt=2.
- Hold during stall: start a 2-bubble stall, assert hold in cycle 2 for 3 cycles -> stall held 5 cycles total, stall_cnt=2.
- Flush abort and reset: start a 2-bubble stall, assert flush in cycle 1 -> stall=0 same cycle, state IDLE next edge. Separately, reset mid-stall -> outputs 0, stall_cnt=0.
- Counter saturation: with CNT_W=4, hold a persistent hazard for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID-stage hazard/forwarding logic:
// forwarding selects, stall FSM states and register-file constants.
package mips_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int REG_ZERO = 0;

  // Worst case is two bubbles (load feeding a branch), so two bits suffice.
  localparam int NEED_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } stall_state_t;

endpackage

// File: rtl/id_src_match.sv
// Per-operand hazard check: picks the forwarding source for one ID operand
// and reports how many bubbles that operand needs before it can be consumed.
module id_src_match
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_used,
  input  logic              i_isBranch,
  input  logic [REG_AW-1:0] i_rdEx,
  input  logic              i_regWriteEx,
  input  logic              i_memReadEx,
  input  logic [REG_AW-1:0] i_rdMem,
  input  logic              i_regWriteMem,
  input  logic              i_memReadMem,
  input  logic [REG_AW-1:0] i_rdWb,
  input  logic              i_regWriteWb,
  output logic [1:0]        o_fwdSel,
  output logic [NEED_W-1:0] o_need
);

  logic w_matchEx;
  logic w_matchMem;
  logic w_matchWb;

  // Register zero is hardwired, so a write to it never creates a dependency.
  assign w_matchEx  = i_used && i_regWriteEx  && (i_rdEx  == i_src) && (i_rdEx  != REG_AW'(REG_ZERO));
  assign w_matchMem = i_used && i_regWriteMem && (i_rdMem == i_src) && (i_rdMem != REG_AW'(REG_ZERO));
  assign w_matchWb  = i_used && i_regWriteWb  && (i_rdWb  == i_src) && (i_rdWb  != REG_AW'(REG_ZERO));

  always_comb begin
    o_fwdSel = FWD_RF;
    if (w_matchMem && !i_memReadMem) begin
      o_fwdSel = FWD_EXMEM;
    end else if (w_matchWb) begin
      o_fwdSel = FWD_MEMWB;
    end
  end

  // Ordered so that the first hit is already the largest bubble count.
  always_comb begin
    o_need = '0;
    if (w_matchEx && i_memReadEx) begin
      o_need = i_isBranch ? NEED_W'(2) : NEED_W'(1);
    end else if (w_matchEx && i_isBranch) begin
      o_need = NEED_W'(1);
    end else if (w_matchMem && i_memReadMem && i_isBranch) begin
      o_need = NEED_W'(1);
    end
  end

endmodule

// File: rtl/id_hazard_fwd_unit.sv
// ID-stage forwarding and hazard unit: per-operand matchers, a bubble
// countdown FSM driving stall/bubble_ex, and a saturating stall counter.
module id_hazard_fwd_unit
  import mips_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] src_id,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic                      is_branch_id,
  input  logic [REG_AW-1:0]         rd_ex,
  input  logic                      reg_write_ex,
  input  logic                      mem_read_ex,
  input  logic [REG_AW-1:0]         rd_mem,
  input  logic                      reg_write_mem,
  input  logic                      mem_read_mem,
  input  logic [REG_AW-1:0]         rd_wb,
  input  logic                      reg_write_wb,
  input  logic                      hold,
  input  logic                      flush,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble_ex,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [2*NUM_SRC-1:0] w_fwdSel;
  logic [NEED_W-1:0]    w_needArr [NUM_SRC];
  logic [NEED_W-1:0]    w_maxNeed;
  logic                 w_stall;

  stall_state_t         r_state;
  logic [NEED_W-1:0]    r_remaining;
  logic [CNT_W-1:0]     r_stallCnt;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    id_src_match #(
      .REG_AW(REG_AW)
    ) u_match (
      .i_src        (src_id[k*REG_AW +: REG_AW]),
      .i_used       (src_used[k]),
      .i_isBranch   (is_branch_id),
      .i_rdEx       (rd_ex),
      .i_regWriteEx (reg_write_ex),
      .i_memReadEx  (mem_read_ex),
      .i_rdMem      (rd_mem),
      .i_regWriteMem(reg_write_mem),
      .i_memReadMem (mem_read_mem),
      .i_rdWb       (rd_wb),
      .i_regWriteWb (reg_write_wb),
      .o_fwdSel     (w_fwdSel[2*k +: 2]),
      .o_need       (w_needArr[k])
    );
  end

  always_comb begin
    w_maxNeed = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_needArr[k] > w_maxNeed) begin
        w_maxNeed = w_needArr[k];
      end
    end
  end

  // In STALL the countdown owns the pipeline; in IDLE the live hazard decides.
  always_comb begin
    w_stall = 1'b0;
    if (!reset && !flush) begin
      w_stall = (r_state == ST_STALL) || (w_maxNeed != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_stallCnt  <= '0;
    end else begin
      if (flush) begin
        r_state     <= ST_IDLE;
        r_remaining <= '0;
      end else if (!hold) begin
        case (r_state)
          ST_IDLE: begin
            if (w_maxNeed > NEED_W'(1)) begin
              r_state     <= ST_STALL;
              r_remaining <= w_maxNeed - NEED_W'(1);
            end
          end
          ST_STALL: begin
            if (r_remaining <= NEED_W'(1)) begin
              r_state     <= ST_IDLE;
              r_remaining <= '0;
            end else begin
              r_remaining <= r_remaining - NEED_W'(1);
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
          end
        endcase
      end

      if (w_stall && !hold && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
    end
  end

  assign stall     = w_stall;
  assign bubble_ex = w_stall;
  assign fwd_sel   = reset ? '0 : w_fwdSel;
  assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// Testbench for id_hazard_fwd_unit: directed hazard scenarios followed by
// randomized traffic, all checked against a bubble-debt reference model.
module tb_id_hazard_fwd_unit;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_SRC*REG_AW-1:0] src_id;
  logic [NUM_SRC-1:0]        src_used;
  logic                      is_branch_id;
  logic [REG_AW-1:0]         rd_ex;
  logic                      reg_write_ex;
  logic                      mem_read_ex;
  logic [REG_AW-1:0]         rd_mem;
  logic                      reg_write_mem;
  logic                      mem_read_mem;
  logic [REG_AW-1:0]         rd_wb;
  logic                      reg_write_wb;
  logic                      hold;
  logic                      flush;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall;
  logic                      bubble_ex;
  logic [CNT_W-1:0]          stall_cnt;

  int vecCount = 0;
  int errCount = 0;

  // Model state: outstanding bubbles still owed and the expected counter.
  int owed = 0;
  int modelCnt = 0;

  id_hazard_fwd_unit #(
    .NUM_SRC(NUM_SRC),
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_id       (src_id),
    .src_used     (src_used),
    .is_branch_id (is_branch_id),
    .rd_ex        (rd_ex),
    .reg_write_ex (reg_write_ex),
    .mem_read_ex  (mem_read_ex),
    .rd_mem       (rd_mem),
    .reg_write_mem(reg_write_mem),
    .mem_read_mem (mem_read_mem),
    .rd_wb        (rd_wb),
    .reg_write_wb (reg_write_wb),
    .hold         (hold),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .bubble_ex    (bubble_ex),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int srcOf(input int k);
    return int'(src_id[k*REG_AW +: REG_AW]);
  endfunction

  function automatic bit hits(input int k, input bit wr, input int rd);
    return src_used[k] && wr && (rd == srcOf(k)) && (rd != 0);
  endfunction

  // Bubbles needed before the ID instruction may read its operands.
  function automatic int modelNeed();
    int worst = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      bit inEx  = hits(k, reg_write_ex, int'(rd_ex));
      bit inMem = hits(k, reg_write_mem, int'(rd_mem));
      int n = 0;
      if (inEx && mem_read_ex) n = is_branch_id ? 2 : 1;
      if (inEx && !mem_read_ex && is_branch_id && n < 1) n = 1;
      if (inMem && mem_read_mem && is_branch_id && n < 1) n = 1;
      if (n > worst) worst = n;
    end
    return worst;
  endfunction

  function automatic logic [2*NUM_SRC-1:0] modelFwd();
    logic [2*NUM_SRC-1:0] sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (hits(k, reg_write_mem, int'(rd_mem)) && !mem_read_mem) sel[2*k +: 2] = 2'b01;
      else if (hits(k, reg_write_wb, int'(rd_wb)))                sel[2*k +: 2] = 2'b10;
    end
    return sel;
  endfunction

  // Checks one cycle's outputs, advances the model across the clock edge,
  // and returns on the following falling edge ready for new inputs.
  task automatic applyStimulus();
    int need;
    bit expStall;
    logic [2*NUM_SRC-1:0] expFwd;
    #1;
    need   = modelNeed();
    expFwd = reset ? '0 : modelFwd();
    if (reset || flush) expStall = 1'b0;
    else                expStall = (owed > 0) || (need > 0);
    checkOutput("fwd_sel",   32'(fwd_sel),   32'(expFwd));
    checkOutput("stall",     32'(stall),     32'(expStall));
    checkOutput("bubble_ex", 32'(bubble_ex), 32'(expStall));
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(modelCnt));
    if (reset) begin
      owed = 0;
      modelCnt = 0;
    end else begin
      if (expStall && !hold && modelCnt < CNT_MAX) modelCnt++;
      if (flush) owed = 0;
      else if (!hold) begin
        if (owed > 0)      owed--;
        else if (need > 0) owed = need - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic clearInputs();
    reset = 1'b0; src_id = '0; src_used = '0; is_branch_id = 1'b0;
    rd_ex = '0; reg_write_ex = 1'b0; mem_read_ex = 1'b0;
    rd_mem = '0; reg_write_mem = 1'b0; mem_read_mem = 1'b0;
    rd_wb = '0; reg_write_wb = 1'b0; hold = 1'b0; flush = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
  endtask

  task automatic setSrc(input int rs, input int rt, input logic [1:0] used);
    src_id = {REG_AW'(rt), REG_AW'(rs)};
    src_used = used;
  endtask

  task automatic startLoadBeq();
    clearInputs();
    setSrc(5, 0, 2'b01);
    is_branch_id = 1'b1;
    rd_ex = 5'd5; reg_write_ex = 1'b1; mem_read_ex = 1'b1;
  endtask

  initial begin
    clearInputs();
    @(negedge clk);
    doReset();
    checkOutput("reset_cnt", 32'(stall_cnt), 32'd0);

    // Write to r0 never forwards or stalls.
    setSrc(0, 0, 2'b11);
    rd_mem = '0; reg_write_mem = 1'b1;
    applyStimulus();
    checkOutput("r0_fwd", 32'(fwd_sel), 32'd0);

    // MEM beats WB for rs; rt only finds WB.
    clearInputs();
    setSrc(8, 9, 2'b11);
    rd_mem = 5'd8; reg_write_mem = 1'b1;
    rd_wb  = 5'd8; reg_write_wb  = 1'b1;
    applyStimulus();
    rd_wb = 5'd9;
    applyStimulus();
    checkOutput("prio_fwd", 32'(fwd_sel), 32'b1001);

    // Load feeding beq: two bubbles as the load walks to WB.
    doReset();
    startLoadBeq();
    applyStimulus();
    rd_ex = 5'd7; mem_read_ex = 1'b0;
    rd_mem = 5'd5; reg_write_mem = 1'b1; mem_read_mem = 1'b1;
    applyStimulus();
    rd_mem = 5'd7; mem_read_mem = 1'b0;
    rd_wb = 5'd5; reg_write_wb = 1'b1;
    applyStimulus();
    checkOutput("ldbeq_cnt", 32'(stall_cnt), 32'd2);
    checkOutput("ldbeq_fwd", 32'(fwd_sel[1:0]), 32'b10);

    // Hold during the second bubble stretches the stall but not the count.
    doReset();
    startLoadBeq();
    applyStimulus();
    hold = 1'b1;
    repeat (3) applyStimulus();
    hold = 1'b0;
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkOutput("hold_cnt", 32'(stall_cnt), 32'd2);

    // Flush kills a pending two-bubble stall in the same cycle.
    doReset();
    startLoadBeq();
    flush = 1'b1; hold = 1'b1;
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkOutput("flush_stall", 32'(stall), 32'd0);

    // Reset in the middle of a stall.
    startLoadBeq();
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    clearInputs();
    applyStimulus();
    checkOutput("rst_mid_cnt", 32'(stall_cnt), 32'd0);

    // Persistent load-use hazard saturates the counter.
    startLoadBeq();
    is_branch_id = 1'b0;
    repeat (20) applyStimulus();
    checkOutput("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));

    // Random traffic over a small register pool to provoke frequent matches.
    clearInputs();
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 99) < 3);
      flush         = ($urandom_range(0, 99) < 8);
      hold          = ($urandom_range(0, 99) < 20);
      setSrc($urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
      is_branch_id  = 1'($urandom_range(0, 1));
      rd_ex         = REG_AW'($urandom_range(0, 3));
      reg_write_ex  = 1'($urandom_range(0, 1));
      mem_read_ex   = 1'($urandom_range(0, 1));
      rd_mem        = REG_AW'($urandom_range(0, 3));
      reg_write_mem = 1'($urandom_range(0, 1));
      mem_read_mem  = 1'($urandom_range(0, 1));
      rd_wb         = REG_AW'($urandom_range(0, 3));
      reg_write_wb  = 1'($urandom_range(0, 1));
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
